spi_burst_sequencer: RTL and testbench
======================================

# spi_burst_sequencer

Multi-word transaction front end that sits directly upstream of the SPI controller. Buffers host TX words in a FIFO, issues them one at a time over the controller's `data_in`/`data_in_valid` handshake, and collects every received word into an RX FIFO. One `start` runs a burst of `len` words and ends with a `done` pulse, so the host never has to track per-word controller handshakes.

## Interface
- `WORD_W`, 8, word width; must equal the controller's `SPI_BITS_PER_WORD`
- `FIFO_DEPTH`, 16, TX and RX FIFO depth; power of two, ≥2
- `LEN_W`, 8, width of `len`
- `FILL_WORD`, 8'hFF, word sent when the TX FIFO is empty mid-burst
- `GAP_CYCLES`, 4, idle cycles between words; used only with `SPI_SEQ_GAP_EN`
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `tx_wr_en`  in  1  push `tx_wr_data` into the TX FIFO
- `tx_wr_data`  in  WORD_W  TX word
- `tx_full`  out  1  TX FIFO full
- `start`  in  1  begin a burst; sampled only while `seq_busy`=0
- `len`  in  LEN_W  number of words in the burst; sampled with `start`
- `seq_busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse at burst end
- `rx_overflow`  out  1  sticky: an RX word was dropped; cleared by an accepted `start`
- `rx_rd_en`  in  1  pop the RX FIFO head
- `rx_rd_data`  out  WORD_W  RX FIFO head (first-word fall-through)
- `rx_empty`  out  1  RX FIFO empty
- `spi_data_in`  out  WORD_W  word to the controller
- `spi_data_in_valid`  out  1  one-cycle issue strobe to the controller
- `spi_data_out`  in  WORD_W  received word from the controller
- `spi_data_out_valid`  in  1  received-word strobe
- `spi_busy`  in  1  controller busy

## Operation
- **States**
  - IDLE: wait for `start`.
  - ISSUE: `spi_data_in_valid`=1 for exactly one cycle; pop TX head, or use `FILL_WORD` if the TX FIFO is empty (no pop).
  - WAIT_RX: wait for `spi_data_out_valid`.
  - WAIT_IDLE: wait for `spi_busy`=0.
  - GAP: only with the macro.
  - DONE: pulse `done`, return to IDLE.
- **Transitions**
  - IDLE→ISSUE on `start` with `len`≠0. Load the remaining counter with `len` and clear `rx_overflow`.
  - `start` with `len`=0 → DONE, with no SPI traffic.
  - ISSUE→WAIT_RX.
  - WAIT_RX→WAIT_IDLE when `spi_data_out_valid`=1. In that same cycle, push `spi_data_out` to the RX FIFO and decrement the counter.
  - WAIT_IDLE, when `spi_busy`=0:
    - counter=0 → DONE.
    - otherwise → GAP with the macro, or → ISSUE without it.
  - GAP→ISSUE after `GAP_CYCLES` cycles.
- **FIFOs**
  - Circular pointers, one extra wrap bit; full/empty come from pointer compare.
  - Write to a full TX FIFO is ignored; contents are unchanged.
  - A simultaneous pop and push on the TX FIFO in ISSUE is legal, including when it is full.
  - RX push when full: drop the word and set `rx_overflow`. If `rx_rd_en` happens in the same cycle, the pop frees a slot and the push succeeds.
  - `rx_rd_en` while empty is ignored.
- `start` while `seq_busy`=1 is ignored. `tx_wr_en` is accepted in any state.
- `spi_data_out_valid` outside WAIT_RX is ignored.
- **Reset mid-burst:** every state and FIFO is cleared immediately. The controller must be reset by the same `rst_n`.

## Timing
- **Reset values:**
  - `tx_full`, `seq_busy`, `done`, `rx_overflow`, `spi_data_in_valid` = 0.
  - `spi_data_in` = 0, `rx_rd_data` = 0.
  - `rx_empty` = 1.
  - State = IDLE.
- **Burst start:** `start` accepted at cycle N. Then `seq_busy`=1 and `spi_data_in_valid`=1 at N+1, with `spi_data_in` stable that cycle.
- **Received word:** `spi_data_out_valid` at cycle M → `rx_empty`=0 and `rx_rd_data` valid at M+1.
- **Next word:** `spi_busy` low first seen at cycle K.
  - Without the macro, the next `spi_data_in_valid` is at K+1.
  - With the macro, it is at K+1+`GAP_CYCLES`.
- **Burst end:** `done`=1 at K+1 after the final word. `seq_busy` drops in the same cycle `done` is high.
- **Empty burst:** `len`=0 gives `done` at N+1 and `seq_busy`=1 for that single cycle.
- **Handshake:** `spi_data_in_valid` is never asserted while `spi_busy`=1. There is at most one outstanding word.

## Configuration
- `SPI_SEQ_GAP_EN` defined: the GAP state and a `GAP_CYCLES` down-counter are compiled in. Every inter-word interval is stretched by `GAP_CYCLES` clocks. There is no gap after the last word.
- Undefined: no GAP state and no counter logic. `GAP_CYCLES` is unused. Words are back-to-back, limited only by `spi_busy`.

## Test plan
- Reset with random inputs → all outputs at their reset values and `rx_empty`=1. Assert `rst_n` mid-burst → `seq_busy`=0 and `rx_empty`=1 at once.
- Push 8'hA5, 8'h3C; `start`, `len`=2; loopback slave (MISO=MOSI) → `spi_data_in` shows A5 then 3C, RX reads A5 then 3C, exactly one `done`.
- `start` with `len`=3 and only 8'h11 queued → words sent are 11, FF, FF; 3 RX words; `done` pulse.
- `len`=0 → `done` one cycle after `start`; `spi_data_in_valid` never asserted.
- Burst of `len`=`FIFO_DEPTH`+2 with no RX reads → the first `FIFO_DEPTH` words are stored, `rx_overflow`=1; the next accepted `start` clears it.
- With `SPI_SEQ_GAP_EN` and `GAP_CYCLES`=4 → exactly 5 cycles from `spi_busy` falling to the next `spi_data_in_valid`. Without the macro → 1 cycle. Check `start` pulses during the burst are ignored.

Source files
------------

// File: rtl/spi_burst_sequencer.sv
// ---------------------------------------------------------------------------
// spi_burst_sequencer
//
// Multi-word transaction front end placed directly upstream of the SPI
// controller. Host TX words are buffered in a FIFO and handed to the
// controller one at a time over its data_in/data_in_valid handshake. Every
// word received back is collected in an RX FIFO. One start runs a burst of
// len words and finishes with a single-cycle done pulse.
//
// Optional feature macro: SPI_SEQ_GAP_EN
//   When defined, a GAP state and a GAP_CYCLES down-counter stretch every
//   inter-word interval by GAP_CYCLES clocks. There is no gap after the last
//   word. When undefined, words go back-to-back, limited only by spi_busy_i.
//
// Ports
//   clk_i                 system clock
//   rst_n_i               asynchronous active-low reset (shared with controller)
//   tx_wr_en_i            push tx_wr_data_i into the TX FIFO
//   tx_wr_data_i          TX word
//   tx_full_o             TX FIFO full
//   start_i               begin a burst (sampled only while idle)
//   len_i                 number of words in the burst, sampled with start_i
//   seq_busy_o            burst in progress
//   done_o                one-cycle pulse at burst end
//   rx_overflow_o         sticky RX-word-dropped flag, cleared by accepted start
//   rx_rd_en_i            pop the RX FIFO head
//   rx_rd_data_o          RX FIFO head (first-word fall-through, 0 when empty)
//   rx_empty_o            RX FIFO empty
//   spi_data_in_o         word to the controller
//   spi_data_in_valid_o   one-cycle issue strobe to the controller
//   spi_data_out_i        received word from the controller
//   spi_data_out_valid_i  received-word strobe
//   spi_busy_i            controller busy
// ---------------------------------------------------------------------------
module spi_burst_sequencer #(
    parameter int unsigned       WORD_W     = 8,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter int unsigned       LEN_W      = 8,
    parameter logic [WORD_W-1:0] FILL_WORD  = WORD_W'(8'hFF),
    parameter int unsigned       GAP_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              tx_wr_en_i,
    input  logic [WORD_W-1:0] tx_wr_data_i,
    output logic              tx_full_o,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              seq_busy_o,
    output logic              done_o,
    output logic              rx_overflow_o,
    input  logic              rx_rd_en_i,
    output logic [WORD_W-1:0] rx_rd_data_o,
    output logic              rx_empty_o,
    output logic [WORD_W-1:0] spi_data_in_o,
    output logic              spi_data_in_valid_o,
    input  logic [WORD_W-1:0] spi_data_out_i,
    input  logic              spi_data_out_valid_i,
    input  logic              spi_busy_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

`ifdef SPI_SEQ_GAP_EN
    localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_RX   = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_GAP       = 3'd4,
        S_DONE      = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_RX   = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_DONE      = 3'd5
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    // Remembers that the current DONE came from a zero-length start, so that
    // seq_busy_o stays high for that single cycle instead of dropping.
    logic               empty_burst_q, empty_burst_d;
    logic               rx_overflow_q;
`ifdef SPI_SEQ_GAP_EN
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
`endif

    // FIFO storage and pointers; pointers carry one extra wrap bit.
    logic [WORD_W-1:0]  tx_mem [FIFO_DEPTH];
    logic [WORD_W-1:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0]        tx_wr_ptr_q, tx_rd_ptr_q;
    logic [AW:0]        rx_wr_ptr_q, rx_rd_ptr_q;

    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_push_req, rx_push, rx_pop, rx_drop;
    logic start_accept;

    assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full  = (tx_wr_ptr_q[AW] != tx_rd_ptr_q[AW]) &&
                      (tx_wr_ptr_q[AW-1:0] == tx_rd_ptr_q[AW-1:0]);
    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full  = (rx_wr_ptr_q[AW] != rx_rd_ptr_q[AW]) &&
                      (rx_wr_ptr_q[AW-1:0] == rx_rd_ptr_q[AW-1:0]);

    // A pop in ISSUE frees the head slot at the same edge, so a push into a
    // full TX FIFO is accepted in that cycle.
    assign tx_pop  = (state_q == S_ISSUE) && !tx_empty;
    assign tx_push = tx_wr_en_i && (!tx_full || tx_pop);

    // Likewise a host pop makes room for a received word in a full RX FIFO.
    assign rx_pop      = rx_rd_en_i && !rx_empty;
    assign rx_push_req = (state_q == S_WAIT_RX) && spi_data_out_valid_i;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_drop     = rx_push_req && rx_full && !rx_pop;

    assign start_accept = (state_q == S_IDLE) && start_i;

    // Sequencer state and burst bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            empty_burst_q <= 1'b0;
`ifdef SPI_SEQ_GAP_EN
            gap_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            empty_burst_q <= empty_burst_d;
`ifdef SPI_SEQ_GAP_EN
            gap_cnt_q     <= gap_cnt_d;
`endif
        end
    end

    // Next-state logic. The remaining counter is decremented when a word is
    // received, so reaching zero in WAIT_IDLE means the burst is complete.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        empty_burst_d = empty_burst_q;
`ifdef SPI_SEQ_GAP_EN
        gap_cnt_d     = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    remaining_d   = len_i;
                    empty_burst_d = (len_i == '0);
                    state_d       = (len_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_RX;
            end
            S_WAIT_RX: begin
                if (spi_data_out_valid_i) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!spi_busy_i) begin
                    if (remaining_q == '0) begin
                        state_d = S_DONE;
                    end else begin
`ifdef SPI_SEQ_GAP_EN
                        // GAP occupies exactly GAP_CYCLES cycles: counts
                        // GAP_CYCLES-1 down to 0, leaving on the zero cycle.
                        gap_cnt_d = GW'(GAP_CYCLES - 1);
                        state_d   = S_GAP;
`else
                        state_d = S_ISSUE;
`endif
                    end
                end
            end
`ifdef SPI_SEQ_GAP_EN
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
`endif
            S_DONE: begin
                empty_burst_d = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // TX FIFO pointers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr_q <= tx_wr_ptr_q + (AW+1)'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr_q <= tx_rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // RX FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_q <= rx_wr_ptr_q + (AW+1)'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + (AW+1)'(1);
            end
            if (start_accept) begin
                rx_overflow_q <= 1'b0;
            end else if (rx_drop) begin
                rx_overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q[AW-1:0]] <= tx_wr_data_i;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q[AW-1:0]] <= spi_data_out_i;
        end
    end

    assign tx_full_o           = tx_full;
    assign rx_empty_o          = rx_empty;
    assign rx_overflow_o       = rx_overflow_q;
    assign rx_rd_data_o        = rx_empty ? '0 : rx_mem[rx_rd_ptr_q[AW-1:0]];
    assign spi_data_in_valid_o = (state_q == S_ISSUE);
    assign spi_data_in_o       = (state_q != S_ISSUE) ? '0 :
                                 (tx_empty ? FILL_WORD : tx_mem[tx_rd_ptr_q[AW-1:0]]);
    assign done_o              = (state_q == S_DONE);
    assign seq_busy_o          = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                                 ((state_q == S_DONE) && empty_burst_q);

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_burst_sequencer
//
// Directed bench for spi_burst_sequencer. A simple SPI slave model answers
// every issued word in loopback (MISO = MOSI). Expected issued words, RX
// reads and done pulses are queued when stimulus is applied; a negedge
// monitor pops and compares them whenever the DUT presents the matching
// output. Honours SPI_SEQ_GAP_EN for the expected inter-word spacing.
// ---------------------------------------------------------------------------
module tb_spi_burst_sequencer;

    localparam int FifoDepth = 16;
    localparam int GapCycles = 4;
`ifdef SPI_SEQ_GAP_EN
    localparam int ExpGap = 1 + GapCycles;
`else
    localparam int ExpGap = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;
    logic       tx_full;
    logic       start;
    logic [7:0] len;
    logic       seq_busy;
    logic       done;
    logic       rx_overflow;
    logic       rx_rd_en;
    logic [7:0] rx_rd_data;
    logic       rx_empty;
    logic [7:0] spi_data_in;
    logic       spi_data_in_valid;
    logic [7:0] spi_data_out;
    logic       spi_data_out_valid;
    logic       spi_busy;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;
    int doneCount = 0;
    int busyFallCycle = 0;
    bit gapArmed = 1'b0;

    logic [7:0] expTx[$];
    logic [7:0] expRx[$];
    bit         expDoneBusy[$];

    spi_burst_sequencer #(
        .WORD_W     (8),
        .FIFO_DEPTH (FifoDepth),
        .LEN_W      (8),
        .FILL_WORD  (8'hFF),
        .GAP_CYCLES (GapCycles)
    ) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .tx_wr_en_i           (tx_wr_en),
        .tx_wr_data_i         (tx_wr_data),
        .tx_full_o            (tx_full),
        .start_i              (start),
        .len_i                (len),
        .seq_busy_o           (seq_busy),
        .done_o               (done),
        .rx_overflow_o        (rx_overflow),
        .rx_rd_en_i           (rx_rd_en),
        .rx_rd_data_o         (rx_rd_data),
        .rx_empty_o           (rx_empty),
        .spi_data_in_o        (spi_data_in),
        .spi_data_in_valid_o  (spi_data_in_valid),
        .spi_data_out_i       (spi_data_out),
        .spi_data_out_valid_i (spi_data_out_valid),
        .spi_busy_i           (spi_busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushTx(input logic [7:0] word);
        tx_wr_en   = 1'b1;
        tx_wr_data = word;
        nextCycle();
        tx_wr_en   = 1'b0;
    endtask

    // Starts a burst; returns one cycle after start was sampled.
    task automatic applyStimulus(input logic [7:0] burstLen);
        start = 1'b1;
        len   = burstLen;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic readRx();
        checkOutput("rxNotEmptyBeforeRead", rx_empty, 0);
        rx_rd_en = 1'b1;
        nextCycle();
        rx_rd_en = 1'b0;
    endtask

    task automatic waitDone(input int startDones, input int budget);
        int n = 0;
        while (doneCount == startDones && n < budget) begin
            nextCycle();
            n++;
        end
        checkOutput("doneWithinBudget", doneCount != startDones, 1);
    endtask

    // Loopback SPI slave: busy one cycle after the issue strobe, returns the
    // same word a few cycles later, then drops busy.
    initial begin : slaveModel
        logic [7:0] word;
        spi_busy           = 1'b0;
        spi_data_out_valid = 1'b0;
        spi_data_out       = '0;
        forever begin
            nextCycle();
            if (spi_data_in_valid === 1'b1) begin
                word = spi_data_in;
                nextCycle();
                spi_busy = 1'b1;
                nextCycle();
                nextCycle();
                spi_data_out       = word;
                spi_data_out_valid = 1'b1;
                nextCycle();
                spi_data_out_valid = 1'b0;
                nextCycle();
                spi_busy      = 1'b0;
                busyFallCycle = cycleCount;
                gapArmed      = 1'b1;
            end
        end
    end

    // Scoreboard monitor: compares DUT outputs against queued expectations.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (spi_data_in_valid === 1'b1) begin
                    checkOutput("busyLowAtIssue", spi_busy, 0);
                    if (gapArmed) begin
                        checkOutput("issueGap", cycleCount - busyFallCycle, ExpGap);
                        gapArmed = 1'b0;
                    end
                    checkOutput("issueExpected", expTx.size() != 0, 1);
                    if (expTx.size() != 0) begin
                        checkOutput("spiDataIn", spi_data_in, expTx.pop_front());
                    end
                end
                if (done === 1'b1) begin
                    doneCount++;
                    gapArmed = 1'b0;
                    checkOutput("doneExpected", expDoneBusy.size() != 0, 1);
                    if (expDoneBusy.size() != 0) begin
                        checkOutput("seqBusyAtDone", seq_busy, expDoneBusy.pop_front());
                    end
                end
                if (rx_rd_en === 1'b1 && rx_empty === 1'b0) begin
                    checkOutput("rxReadExpected", expRx.size() != 0, 1);
                    if (expRx.size() != 0) begin
                        checkOutput("rxRdData", rx_rd_data, expRx.pop_front());
                    end
                end
            end
        end
    end

    initial begin : main
        int d;
        rst_n      = 1'b0;
        tx_wr_en   = 1'b0;
        tx_wr_data = '0;
        start      = 1'b0;
        len        = '0;
        rx_rd_en   = 1'b0;

        // Reset with random host inputs.
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            tx_wr_en   = 1'($urandom);
            tx_wr_data = 8'($urandom);
            start      = 1'($urandom);
            len        = 8'($urandom);
            rx_rd_en   = 1'($urandom);
        end
        #1;
        checkOutput("resetTxFull", tx_full, 0);
        checkOutput("resetSeqBusy", seq_busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetRxOverflow", rx_overflow, 0);
        checkOutput("resetIssueValid", spi_data_in_valid, 0);
        checkOutput("resetSpiDataIn", spi_data_in, 0);
        checkOutput("resetRxRdData", rx_rd_data, 0);
        checkOutput("resetRxEmpty", rx_empty, 1);
        tx_wr_en = 1'b0;
        start    = 1'b0;
        len      = '0;
        rx_rd_en = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Two-word loopback burst, with ignored start pulses mid-burst.
        pushTx(8'hA5);
        pushTx(8'h3C);
        expTx.push_back(8'hA5);
        expTx.push_back(8'h3C);
        expRx.push_back(8'hA5);
        expRx.push_back(8'h3C);
        expDoneBusy.push_back(1'b0);
        d = doneCount;
        applyStimulus(8'd2);
        checkOutput("issueOneCycleAfterStart", spi_data_in_valid, 1);
        checkOutput("busyOneCycleAfterStart", seq_busy, 1);
        repeat (3) nextCycle();
        start = 1'b1;
        len   = 8'd5;
        nextCycle();
        start = 1'b0;
        waitDone(d, 200);
        checkOutput("seqBusyAfterDone", seq_busy, 0);
        repeat (10) nextCycle();
        readRx();
        readRx();
        checkOutput("rxEmptyAfterLoopback", rx_empty, 1);

        // Short TX FIFO: one real word then fill words.
        pushTx(8'h11);
        expTx.push_back(8'h11);
        expTx.push_back(8'hFF);
        expTx.push_back(8'hFF);
        expRx.push_back(8'h11);
        expRx.push_back(8'hFF);
        expRx.push_back(8'hFF);
        expDoneBusy.push_back(1'b0);
        d = doneCount;
        applyStimulus(8'd3);
        waitDone(d, 300);
        readRx();
        readRx();
        readRx();
        checkOutput("rxEmptyAfterFill", rx_empty, 1);

        // Zero-length burst.
        expDoneBusy.push_back(1'b1);
        applyStimulus(8'd0);
        checkOutput("doneAfterEmptyStart", done, 1);
        checkOutput("busyDuringEmptyDone", seq_busy, 1);
        nextCycle();
        checkOutput("donePulseEnds", done, 0);
        checkOutput("idleAfterEmptyBurst", seq_busy, 0);

        // Full TX FIFO, push-while-pop, and RX overflow.
        for (int i = 0; i < FifoDepth; i++) begin
            pushTx(8'h20 + 8'(i));
            expTx.push_back(8'h20 + 8'(i));
            expRx.push_back(8'h20 + 8'(i));
        end
        checkOutput("txFullAtDepth", tx_full, 1);
        pushTx(8'hDD);
        checkOutput("txFullAfterIgnoredPush", tx_full, 1);
        expTx.push_back(8'hEE);
        expTx.push_back(8'hFF);
        expDoneBusy.push_back(1'b0);
        d = doneCount;
        applyStimulus(8'(FifoDepth + 2));
        tx_wr_en   = 1'b1;
        tx_wr_data = 8'hEE;
        nextCycle();
        tx_wr_en   = 1'b0;
        checkOutput("txFullAfterPopPush", tx_full, 1);
        waitDone(d, 600);
        checkOutput("rxOverflowSet", rx_overflow, 1);
        for (int i = 0; i < FifoDepth; i++) begin
            readRx();
        end
        checkOutput("rxEmptyAfterDrain", rx_empty, 1);
        checkOutput("rxOverflowSticky", rx_overflow, 1);
        expDoneBusy.push_back(1'b1);
        applyStimulus(8'd0);
        checkOutput("rxOverflowCleared", rx_overflow, 0);
        nextCycle();

        // Reset in the middle of a burst.
        pushTx(8'h41);
        pushTx(8'h42);
        pushTx(8'h43);
        expTx.push_back(8'h41);
        expTx.push_back(8'h42);
        expTx.push_back(8'h43);
        applyStimulus(8'd4);
        repeat (6) nextCycle();
        checkOutput("rxHoldsWordBeforeReset", rx_empty, 0);
        checkOutput("busyBeforeReset", seq_busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("busyClearedByReset", seq_busy, 0);
        checkOutput("rxEmptyAfterReset", rx_empty, 1);
        checkOutput("issueClearedByReset", spi_data_in_valid, 0);
        expTx.delete();
        expDoneBusy.delete();
        repeat (3) nextCycle();
        rst_n = 1'b1;
        repeat (20) nextCycle();
        gapArmed = 1'b0;
        checkOutput("rxEmptyAfterIgnoredRx", rx_empty, 1);
        checkOutput("idleAfterReset", seq_busy, 0);

        checkOutput("txQueueDrained", expTx.size(), 0);
        checkOutput("rxQueueDrained", expRx.size(), 0);
        checkOutput("doneQueueDrained", expDoneBusy.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
